// File: rtl/adder_arbiter.sv
// Two-requester arbiter sharing one N-bit adder with a single registered result slot.
// Define ADDER_ARBITER_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module adder_arbiter #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   input  logic         req0_cin,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   input  logic         req1_cin,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [N-1:0] res_sum,
   output logic         res_cout,
   output logic         res_id
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t       state_q, state_d;
   logic [N-1:0] sum_q, sum_d;
   logic         cout_q, cout_d;
   logic         id_q, id_d;
   logic         outFree;
   logic         grant0, grant1;
   logic         transfer;
   logic         selId;
   logic [N:0]   sumFull;

`ifdef ADDER_ARBITER_RR_EN
   logic         last_q, last_d;

   // On contention the requester not granted last wins; pointer resets to 1 so req0 wins first.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (req0_valid && req1_valid) begin
         grant0 = last_q;
         grant1 = !last_q;
      end else begin
         grant0 = req0_valid;
         grant1 = req1_valid;
      end
   end

   always_comb begin
      last_d = last_q;
      if (transfer) begin
         last_d = selId;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   always_comb begin
      grant0 = req0_valid;
      grant1 = req1_valid && !req0_valid;
   end
`endif

   // Readies are held low during reset even though the slot looks free.
   always_comb begin
      outFree    = (state_q == EMPTY) || res_ready;
      req0_ready = rst && grant0 && outFree;
      req1_ready = rst && grant1 && outFree;
      transfer   = req0_ready || req1_ready;
      selId      = req1_ready;
   end

   always_comb begin
      sumFull = '0;
      if (selId) begin
         sumFull = {1'b0, req1_a} + {1'b0, req1_b} + {{N{1'b0}}, req1_cin};
      end else begin
         sumFull = {1'b0, req0_a} + {1'b0, req0_b} + {{N{1'b0}}, req0_cin};
      end
   end

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      id_d    = id_q;
      if (transfer) begin
         state_d = FULL;
         sum_d   = sumFull[N-1:0];
         cout_d  = sumFull[N];
         id_d    = selId;
      end else if (state_q == FULL && res_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         id_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         id_q    <= id_d;
      end
   end

   assign res_valid = (state_q == FULL);
   assign res_sum   = sum_q;
   assign res_cout  = cout_q;
   assign res_id    = id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter; expected values are hand-computed.
// Expectations for contention follow ADDER_ARBITER_RR_EN when it is defined.
module tb_adder_arbiter;

   logic        clk;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        req0_cin, req1_cin;
   logic        res_valid, res_ready;
   logic [31:0] res_sum;
   logic        res_cout, res_id;

   int checks;
   int failures;

   adder_arbiter #(.N(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_cin   (req0_cin),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_cin   (req1_cin),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_sum    (res_sum),
      .res_cout   (res_cout),
      .res_id     (res_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; registered outputs are sampled 1 time unit after the rising edge.
   task automatic drain();
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res_ready  = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      res_ready = 1'b1;
      req0_a = 32'h1; req0_b = 32'h1; req0_cin = 1'b0;
      req1_a = 32'h2; req1_b = 32'h2; req1_cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({res_valid, res_cout, res_id, req0_ready, req1_ready} !== 5'b0) begin
         failures++;
         $display("[TB] FAIL reset_flags got=%b want=00000",
                  {res_valid, res_cout, res_id, req0_ready, req1_ready});
      end
      checks++;
      if (res_sum !== 32'h0) begin
         failures++;
         $display("[TB] FAIL reset_sum got=%h want=00000000", res_sum);
      end
      @(negedge clk);
      rst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic test_req0_single();
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 32'h5; req0_b = 32'h3; req0_cin = 1'b1;
      res_ready = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         failures++;
         $display("[TB] FAIL req0_ready got=%b want=10", {req0_ready, req1_ready});
      end
      @(posedge clk);
      #1;
      checks++;
      if ({res_valid, res_sum, res_cout, res_id} !== {1'b1, 32'h9, 1'b0, 1'b0}) begin
         failures++;
         $display("[TB] FAIL req0_result got v=%b s=%h c=%b id=%b want v=1 s=00000009 c=0 id=0",
                  res_valid, res_sum, res_cout, res_id);
      end
      drain();
      checks++;
      if (res_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL drain_empty got=%b want=0", res_valid);
      end
   endtask

   task automatic test_req1_wrap();
      @(negedge clk);
      req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'h1; req1_cin = 1'b0;
      res_ready = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         failures++;
         $display("[TB] FAIL req1_ready got=%b want=01", {req0_ready, req1_ready});
      end
      @(posedge clk);
      #1;
      checks++;
      if ({res_valid, res_sum, res_cout, res_id} !== {1'b1, 32'h0, 1'b1, 1'b1}) begin
         failures++;
         $display("[TB] FAIL req1_wrap got v=%b s=%h c=%b id=%b want v=1 s=00000000 c=1 id=1",
                  res_valid, res_sum, res_cout, res_id);
      end
      drain();
   endtask

   task automatic test_contention();
      logic [3:0] wantId;
      logic [3:0] wantR1;
`ifdef ADDER_ARBITER_RR_EN
      wantId = 4'b1010;
`else
      wantId = 4'b0000;
`endif
      wantR1 = wantId;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         req0_valid = 1'b1; req0_a = 32'h1;  req0_b = 32'h1;  req0_cin = 1'b0;
         req1_valid = 1'b1; req1_a = 32'h10; req1_b = 32'h10; req1_cin = 1'b0;
         res_ready = 1'b1;
         #1;
         checks++;
         if (req1_ready !== wantR1[i]) begin
            failures++;
            $display("[TB] FAIL contend_ready%0d got=%b want=%b", i, req1_ready, wantR1[i]);
         end
         @(posedge clk);
         #1;
         checks++;
         if (res_id !== wantId[i] || res_sum !== (wantId[i] ? 32'h20 : 32'h2) || res_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL contend_result%0d got id=%b s=%h v=%b want id=%b s=%h v=1",
                     i, res_id, res_sum, res_valid, wantId[i], (wantId[i] ? 32'h20 : 32'h2));
         end
      end
      drain();
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_cin = 1'b0;
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      req0_a = 32'd100; req0_b = 32'd1; req0_cin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (req0_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_ready%0d got=%b want=0", i, req0_ready);
         end
         @(posedge clk);
         #1;
         checks++;
         if ({res_valid, res_sum, res_id} !== {1'b1, 32'd30, 1'b0}) begin
            failures++;
            $display("[TB] FAIL stall_hold%0d got v=%b s=%h id=%b want v=1 s=0000001e id=0",
                     i, res_valid, res_sum, res_id);
         end
         @(negedge clk);
      end
      res_ready = 1'b1;
      #1;
      checks++;
      if (req0_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL b2b_ready got=%b want=1", req0_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({res_valid, res_sum} !== {1'b1, 32'd101}) begin
         failures++;
         $display("[TB] FAIL b2b_result got v=%b s=%h want v=1 s=00000065", res_valid, res_sum);
      end
      drain();
   endtask

   task automatic test_reset_midop();
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd7; req0_cin = 1'b0;
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0;
      res_ready = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({res_valid, res_sum, res_cout, res_id} !== 35'b0) begin
         failures++;
         $display("[TB] FAIL midop_reset got v=%b s=%h c=%b id=%b want all zero",
                  res_valid, res_sum, res_cout, res_id);
      end
      @(negedge clk);
      rst = 1'b1;
      req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_cin = 1'b0;
      req1_valid = 1'b1; req1_a = 32'd8; req1_b = 32'd8; req1_cin = 1'b0;
      res_ready = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         failures++;
         $display("[TB] FAIL post_reset_grant got=%b want=10", {req0_ready, req1_ready});
      end
      @(posedge clk);
      #1;
      checks++;
      if ({res_valid, res_sum, res_id} !== {1'b1, 32'd7, 1'b0}) begin
         failures++;
         $display("[TB] FAIL post_reset_result got v=%b s=%h id=%b want v=1 s=00000007 id=0",
                  res_valid, res_sum, res_id);
      end
      drain();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_req0_single();
      test_req1_wrap();
      test_contention();
      test_back_to_back();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter N, default 32, operand and sum width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester k presents an operation.
REQ-005 req0_ready / req1_ready  output  1 each  requester k's operation accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  N each  operands from requester k.
REQ-007 req0_cin / req1_cin  input  1 each  carry-in from requester k.
REQ-008 res_valid  output  1  result register holds a valid result.
REQ-009 res_ready  input  1  consumer accepts the result this cycle.
REQ-010 res_sum  output  N  registered sum, a + b + cin modulo 2^N.
REQ-011 res_cout  output  1  registered carry-out, bit N of a + b + cin.
REQ-012 res_id  output  1  index of the requester that produced the result.

Function
REQ-013 The block SHALL share one N-bit add datapath between two requesters, using a single-entry registered result stage.
REQ-014 A transfer on port k occurs when reqk_valid and reqk_ready are both high at a rising edge.
REQ-015 Output stage is "free" when res_valid is 0, or when res_valid and res_ready are both 1 in the same cycle.
REQ-016 reqk_ready SHALL be high only when requester k is granted, reqk_valid is high and the output stage is free; at most one ready is high per cycle.
REQ-017 Ready SHALL be combinational from the valids, res_valid and res_ready; there is no bubble, giving one operation per cycle while res_ready stays high.
REQ-018 On a transfer, res_sum, res_cout and res_id SHALL load on that edge; res_valid is high in the next cycle, for a latency of 1 cycle.
REQ-019 State: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-020 EMPTY->FULL on a transfer.
REQ-021 FULL->EMPTY on a result handshake with no new transfer.
REQ-022 FULL->FULL on a result handshake together with a new transfer (back-to-back), or when res_ready is low.
REQ-023 While FULL and res_ready is low, res_sum, res_cout and res_id SHALL hold stable.
REQ-024 Only one valid high: that requester is granted.
REQ-025 Both valid: the grant follows the arbitration policy in REQ-031/REQ-032.
REQ-026 Arithmetic SHALL be unsigned.
REQ-027 0xFFFFFFFF + 0x00000001 + 0 wraps to res_sum=0x00000000 with res_cout=1, and no other flag is raised.
REQ-028 Requesters SHALL hold a, b and cin stable while valid is high and ready is low; the block does not latch inputs before a transfer.

Reset
REQ-029 While rst=0: res_valid=0, res_sum=0, res_cout=0, res_id=0, and both readies are 0.
REQ-030 Reset asserted mid-operation SHALL discard any held result without a handshake; the arbitration pointer returns to favour requester 0.

Configuration
REQ-031 Macro ADDER_ARBITER_RR_EN defined: round-robin arbitration.
- Last-granted pointer, reset value 1, so requester 0 wins the first contention.
- On contention the grant goes to the requester not granted last.
- The pointer updates only on a transfer.
REQ-032 Macro undefined: fixed priority; requester 0 always wins contention, no pointer register.

Verification
REQ-033 Reset, then req0 only, a=0x00000005, b=0x00000003, cin=1, res_ready=1 -> req0_ready=1, next cycle res_valid=1, res_sum=0x00000009, res_cout=0, res_id=0.
REQ-034 req1 only, a=0xFFFFFFFF, b=0x00000001, cin=0 -> res_sum=0x00000000, res_cout=1, res_id=1.
REQ-035 Both valid every cycle for 4 cycles, res_ready=1:
- With ADDER_ARBITER_RR_EN: res_id sequence 0,1,0,1.
- Without it: 0,0,0,0, and req1_ready stays 0.
REQ-036 Transfer, then res_ready=0 for 3 cycles with req0_valid high -> res_valid stays 1, result unchanged, req0_ready=0; res_ready=1 -> handshake and new transfer in the same cycle, res_valid stays 1.
REQ-037 rst pulsed low while res_valid=1 and res_ready=0 -> outputs immediately zero; after release, the first contention grants requester 0.
